// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 32x32 architectural register file.
// Selects ALU, aligned load data or PC+4 as the result, commits it to rd, and
// serves two combinational read ports with write-first bypass of the commit.
// x0 is never written and always reads zero.
// Optional feature macro: INSTRET_EN builds the 64-bit retired-instruction
// counter. When it is undefined, instret is tied to zero and no counter flops exist.
module wb_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              wb_valid,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd,
    input  logic [1:0]        result_sel,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [XLEN-1:0]   pcPlus4,
    input  logic [2:0]        ld_funct3,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [63:0]       instret
);

    // Extract the addressed byte/halfword and extend it. Misalignment is ignored:
    // LH uses only offset bit 1, and LW uses neither offset bit.
    function automatic logic [XLEN-1:0] align_load(
        input logic [XLEN-1:0] word,
        input logic [1:0]      off,
        input logic [2:0]      f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[16 +: 16] : word[0 +: 16];
        case (f3)
            3'b000:  align_load = {{(XLEN-8){b[7]}}, b};
            3'b001:  align_load = {{(XLEN-16){h[15]}}, h};
            3'b100:  align_load = {{(XLEN-8){1'b0}}, b};
            3'b101:  align_load = {{(XLEN-16){1'b0}}, h};
            default: align_load = word;
        endcase
    endfunction

    logic [XLEN-1:0] regs_q [NREGS];
    logic            retire;
    logic            commit;
    logic [XLEN-1:0] result;

    assign retire = wb_valid & ~stall;
    assign commit = retire & reg_write & (rd != '0);

    // Result select; the reserved encoding falls back to the ALU result.
    always_comb begin
        result = alu_result;
        case (result_sel)
            2'b01:   result = align_load(mem_data, alu_result[1:0], ld_funct3);
            2'b10:   result = pcPlus4;
            default: result = alu_result;
        endcase
    end

    assign wb_we   = commit;
    assign wb_rd   = rd;
    assign wb_data = result;

    // Read ports: x0 reads zero; a same-cycle commit to the read address wins.
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        rs2_data = regs_q[rs2_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (commit && (rs1_addr == rd)) begin
            rs1_data = result;
        end
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (commit && (rs2_addr == rd)) begin
            rs2_data = result;
        end
    end

    // Register file storage: cleared on reset, rd takes the result on commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[rd] <= result;
        end
    end

`ifdef INSTRET_EN
    logic [63:0] instret_q;
    logic [63:0] instret_d;

    // Retire counter next state: counts every non-stalled valid instruction, wrapping at 2^64.
    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 64'd0;
`endif

endmodule
